// File: rtl/riscv_single_cycle_core_pkg.sv
// Shared decode constants, control enums and instruction encode/immediate
// helpers for the single-cycle RV32I-subset core.
package riscv_single_cycle_core_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_NOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_W   = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4,
      ALU_NOR = 4'd5
   } alu_ctrl_e;

   typedef enum logic [0:0] {
      IMM_I = 1'b0,
      IMM_S = 1'b1
   } imm_sel_e;

   // Sign-extended 12-bit immediate in I or S layout.
   function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_sel_e sel);
      if (sel == IMM_S) return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   // Encoders used to build the program ROM readably.
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_RTYPE};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
   endfunction

endpackage

// File: rtl/riscv_single_cycle_core_if.sv
// Decode bus between the datapath (instruction fields out) and the
// hardwired controller (control strobes out).
interface riscv_single_cycle_core_if;
   import riscv_single_cycle_core_pkg::*;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       reg_write;
   logic       alu_src;
   logic       mem_write;
   logic       mem_to_reg;
   imm_sel_e   imm_sel;
   alu_ctrl_e  alu_ctrl;

   modport master (input opcode, funct3, funct7,
                   output reg_write, alu_src, mem_write, mem_to_reg, imm_sel, alu_ctrl);
   modport slave  (output opcode, funct3, funct7,
                   input reg_write, alu_src, mem_write, mem_to_reg, imm_sel, alu_ctrl);
endinterface

// File: rtl/riscv_single_cycle_core_control_unit.sv
// Hardwired main + ALU decoder. Unknown opcodes/functs decode to
// "no write, add" so an all-zero word behaves as a harmless bubble.
module riscv_control_unit
   import riscv_single_cycle_core_pkg::*;
(
   riscv_single_cycle_core_if.master ctrl
);

   // Decode opcode/funct fields into datapath strobes.
   always_comb begin
      ctrl.reg_write  = 1'b0;
      ctrl.alu_src    = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.imm_sel    = IMM_I;
      ctrl.alu_ctrl   = ALU_ADD;
      case (ctrl.opcode)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            case (ctrl.funct3)
               F3_ADD: begin
                  if (ctrl.funct7 == F7_SUB)       ctrl.alu_ctrl = ALU_SUB;
                  else if (ctrl.funct7 != F7_BASE) ctrl.reg_write = 1'b0;
               end
               F3_AND:  ctrl.alu_ctrl = ALU_AND;
               F3_OR:   ctrl.alu_ctrl = ALU_OR;
               F3_SLT:  ctrl.alu_ctrl = ALU_SLT;
               F3_NOR:  ctrl.alu_ctrl = ALU_NOR;
               default: ctrl.reg_write = 1'b0;
            endcase
         end
         OP_ITYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            case (ctrl.funct3)
               F3_ADD:  ctrl.alu_ctrl = ALU_ADD;
               F3_AND:  ctrl.alu_ctrl = ALU_AND;
               F3_OR:   ctrl.alu_ctrl = ALU_OR;
               F3_SLT:  ctrl.alu_ctrl = ALU_SLT;
               F3_NOR:  ctrl.alu_ctrl = ALU_NOR;
               default: ctrl.reg_write = 1'b0;
            endcase
         end
         OP_LOAD: begin
            ctrl.alu_src = 1'b1;
            if (ctrl.funct3 == F3_W) begin
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
            end
         end
         OP_STORE: begin
            ctrl.alu_src = 1'b1;
            ctrl.imm_sel = IMM_S;
            if (ctrl.funct3 == F3_W) ctrl.mem_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I-subset core with program ROM, register file, ALU and
// word-addressed data RAM. Result is the combinational ALU output of the
// instruction at PC. Optional macro RESULT_WB_EN makes Result show the
// register write-back value instead (load data for LW).
// DMEM_WORDS must be a power of two (RAM index is address[31:2] modulo depth).
module riscv_single_cycle_core
   import riscv_single_cycle_core_pkg::*;
#(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] Result
);

   localparam int DMEM_AW = $clog2(DMEM_WORDS);

   riscv_single_cycle_core_if ctrl_if ();

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr, imm, rs1_data, rs2_data, alu_b, alu_result, dmem_rdata, wb_data;
   logic [4:0]  rs1, rs2, rd;
   logic [DMEM_AW-1:0] dmem_idx;
   logic [31:0] rf   [32];
   logic [31:0] dmem [DMEM_WORDS];

   // Preloaded program; anything past it reads as zero.
   function automatic logic [31:0] rom_word(input logic [29:0] idx);
      case (idx)
         30'd0:   return enc_r(F7_BASE, 5'd0, 5'd0, F3_AND, 5'd0);
         30'd1:   return enc_i(12'd1, 5'd0, F3_ADD, 5'd1, OP_ITYPE);
         30'd2:   return enc_i(12'd2, 5'd0, F3_ADD, 5'd2, OP_ITYPE);
         30'd3:   return enc_i(12'd3, 5'd1, F3_ADD, 5'd3, OP_ITYPE);
         30'd4:   return enc_i(12'd4, 5'd1, F3_ADD, 5'd4, OP_ITYPE);
         30'd5:   return enc_i(12'd5, 5'd2, F3_ADD, 5'd5, OP_ITYPE);
         30'd6:   return enc_i(12'd6, 5'd2, F3_ADD, 5'd6, OP_ITYPE);
         30'd7:   return enc_i(12'd7, 5'd3, F3_ADD, 5'd7, OP_ITYPE);
         30'd8:   return enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd8);
         30'd9:   return enc_r(F7_SUB,  5'd4, 5'd8, F3_ADD, 5'd9);
         30'd10:  return enc_r(F7_BASE, 5'd3, 5'd2, F3_AND, 5'd10);
         30'd11:  return enc_r(F7_BASE, 5'd4, 5'd3, F3_OR,  5'd11);
         30'd12:  return enc_r(F7_BASE, 5'd4, 5'd3, F3_SLT, 5'd12);
         30'd13:  return enc_r(F7_BASE, 5'd7, 5'd6, F3_NOR, 5'd13);
         30'd14:  return enc_i(12'h4D3, 5'd9,  F3_AND, 5'd14, OP_ITYPE);
         30'd15:  return enc_i(12'h8D3, 5'd11, F3_OR,  5'd15, OP_ITYPE);
         30'd16:  return enc_i(12'h4D2, 5'd13, F3_SLT, 5'd16, OP_ITYPE);
         30'd17:  return enc_i(12'h4D2, 5'd8,  F3_NOR, 5'd17, OP_ITYPE);
         30'd18:  return enc_s(12'd48, 5'd11, 5'd0, F3_W);
         30'd19:  return enc_i(12'd48, 5'd0, F3_W, 5'd12, OP_LOAD);
         default: return 32'h0;
      endcase
   endfunction

   // PC: async clear, otherwise advance one word per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= 32'h0;
      else       pc_q <= pc_d;
   end

   // Fetch, decode, register read, ALU and write-back selection.
   always_comb begin
      pc_d     = pc_q + 32'd4;
      instr    = (pc_q[31:2] < 30'(IMEM_WORDS)) ? rom_word(pc_q[31:2]) : 32'h0;
      rs1      = instr[19:15];
      rs2      = instr[24:20];
      rd       = instr[11:7];
      imm      = imm_gen(instr, ctrl_if.imm_sel);
      rs1_data = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
      rs2_data = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
      alu_b    = ctrl_if.alu_src ? imm : rs2_data;
      case (ctrl_if.alu_ctrl)
         ALU_ADD: alu_result = rs1_data + alu_b;
         ALU_SUB: alu_result = rs1_data - alu_b;
         ALU_AND: alu_result = rs1_data & alu_b;
         ALU_OR:  alu_result = rs1_data | alu_b;
         ALU_SLT: alu_result = {31'b0, $signed(rs1_data) < $signed(alu_b)};
         ALU_NOR: alu_result = ~(rs1_data | alu_b);
         default: alu_result = 32'h0;
      endcase
      dmem_idx   = alu_result[DMEM_AW+1:2];
      dmem_rdata = dmem[dmem_idx];
      wb_data    = ctrl_if.mem_to_reg ? dmem_rdata : alu_result;
`ifdef RESULT_WB_EN
      Result     = ctrl_if.reg_write ? wb_data : alu_result;
`else
      Result     = alu_result;
`endif
   end

   assign ctrl_if.opcode = instr[6:0];
   assign ctrl_if.funct3 = instr[14:12];
   assign ctrl_if.funct7 = instr[31:25];

   riscv_control_unit u_ctrl (.ctrl(ctrl_if.master));

   // Register file write port; x0 is never stored.
   always_ff @(posedge clk) begin
      if (ctrl_if.reg_write && rd != 5'd0) rf[rd] <= wb_data;
   end

   // Data RAM write port.
   always_ff @(posedge clk) begin
      if (ctrl_if.mem_write) dmem[dmem_idx] <= rs2_data;
   end

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Self-checking bench: table of expected Results per program entry, fed
// through a scoreboard queue, plus reset/past-end corner sequences.
module tb_riscv_single_cycle_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Result;

   riscv_single_cycle_core #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
      .clk(clk), .reset(reset), .Result(Result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [20];
   logic [31:0] sb_q [$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] rf_snap [32];
   logic [31:0] dm_snap [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive n program entries: push expectation, compare, advance one edge.
   task automatic run_seq(input int n, input string tag);
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(tbl[i].exp);
         e = sb_q.pop_front();
         check($sformatf("%s[%0d] %s", tag, i + 1, tbl[i].name), Result, e);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      int diffs;
      tbl[0]  = '{"and x0",  32'h0000_0000};
      tbl[1]  = '{"addi x1", 32'h0000_0001};
      tbl[2]  = '{"addi x2", 32'h0000_0002};
      tbl[3]  = '{"addi x3", 32'h0000_0004};
      tbl[4]  = '{"addi x4", 32'h0000_0005};
      tbl[5]  = '{"addi x5", 32'h0000_0007};
      tbl[6]  = '{"addi x6", 32'h0000_0008};
      tbl[7]  = '{"addi x7", 32'h0000_000B};
      tbl[8]  = '{"add x8",  32'h0000_0003};
      tbl[9]  = '{"sub x9",  32'hFFFF_FFFE};
      tbl[10] = '{"and x10", 32'h0000_0000};
      tbl[11] = '{"or x11",  32'h0000_0005};
      tbl[12] = '{"slt x12", 32'h0000_0001};
      tbl[13] = '{"nor x13", 32'hFFFF_FFF4};
      tbl[14] = '{"andi x14", 32'h0000_04D2};
      tbl[15] = '{"ori x15",  32'hFFFF_F8D7};
      tbl[16] = '{"slti x16", 32'h0000_0001};
      tbl[17] = '{"nori x17", 32'hFFFF_FB2C};
      tbl[18] = '{"sw",       32'h0000_0030};
`ifdef RESULT_WB_EN
      tbl[19] = '{"lw",       32'h0000_0005};
`else
      tbl[19] = '{"lw",       32'h0000_0030};
`endif

      // Reset over one edge.
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset pc", dut.pc_q, 32'h0);
      check("reset result", Result, 32'h0);
      reset = 1'b0;

      // Full program.
      run_seq(20, "run1");
      check("x12 after lw", dut.rf[12], 32'h5);
      check("dmem[12]", dut.dmem[12], 32'h5);
      check("x15 ori sext", dut.rf[15], 32'hFFFF_F8D7);
      check("x16 slti signed", dut.rf[16], 32'h1);

      // Past the program end: zero words, no side effects.
      for (int i = 0; i < 32; i++) rf_snap[i] = dut.rf[i];
      for (int i = 0; i < 64; i++) dm_snap[i] = dut.dmem[i];
      for (int c = 0; c < 6; c++) begin
         check($sformatf("past end result c%0d", c), Result, 32'h0);
         check($sformatf("past end x0 read c%0d", c), dut.rs1_data, 32'h0);
         @(posedge clk);
         @(negedge clk);
      end
      diffs = 0;
      for (int i = 1; i < 32; i++) if (dut.rf[i] !== rf_snap[i]) diffs++;
      check("past end rf writes", 32'(diffs), 32'h0);
      diffs = 0;
      for (int i = 0; i < 64; i++) if (dut.dmem[i] !== dm_snap[i]) diffs++;
      check("past end dmem writes", 32'(diffs), 32'h0);

      // Restart, run 10 entries, then async reset between edges.
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_seq(10, "run2");
      check("pre-reset result", Result, tbl[10].exp);
      #2 reset = 1'b1;
      #1;
      check("async reset result", Result, 32'h0);
      check("async reset pc", dut.pc_q, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("held reset pc", dut.pc_q, 32'h0);
      reset = 1'b0;
      run_seq(20, "run3");
      check("x12 after rerun", dut.rf[12], 32'h5);
      check("dmem[12] after rerun", dut.dmem[12], 32'h5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
